// File: rtl/frame_buffer_writer_if.sv
// Pixel-in / memory-out bus of the frame buffer writer.
// The rasterizer/arbiter/display side drives through master, the writer sits on slave.
interface frame_buffer_writer_if;
  logic        px_wr_en;
  logic [9:0]  px_x;
  logic [8:0]  px_y;
  logic [2:0]  px_color;
  logic        raster_done;
  logic        vsync;
  logic        mem_wr_gnt;
  logic        frame_ready;
  logic        mem_wr_req;
  logic [19:0] mem_addr;
  logic [2:0]  mem_wdata;
  logic        disp_bank;
  logic        swap_done;
  logic [15:0] oob_cnt;

  modport master (
    output px_wr_en, px_x, px_y, px_color, raster_done, vsync, mem_wr_gnt,
    input  frame_ready, mem_wr_req, mem_addr, mem_wdata, disp_bank, swap_done, oob_cnt
  );

  modport slave (
    input  px_wr_en, px_x, px_y, px_color, raster_done, vsync, mem_wr_gnt,
    output frame_ready, mem_wr_req, mem_addr, mem_wdata, disp_bank, swap_done, oob_cnt
  );
endinterface

// File: rtl/frame_buffer_writer.sv
// Double-buffered frame buffer writer: accepts one pixel at a time from the
// rasterizer, writes it into the draw bank, and swaps draw/display banks on
// the first vsync after the rasterizer reports the frame complete.
module frame_buffer_writer (
  input  logic                  clk,
  input  logic                  rst,
  frame_buffer_writer_if.slave  bus
);

  typedef enum logic [1:0] {
    ACCEPT    = 2'd0,
    WRITE     = 2'd1,
    SWAP_WAIT = 2'd2
  } state_e;

  state_e      state_q;
  logic        draw_bank_q;
  logic        swap_pend_q;
  logic        swap_done_q;
  logic [15:0] oob_cnt_q;
  logic [19:0] mem_addr_q;
  logic [2:0]  mem_wdata_q;

  logic        swap_pend_d;
  logic [15:0] oob_cnt_d;
  logic [18:0] lin_addr;
  logic        in_range;

  // A raster_done arriving this cycle counts as pending for this cycle's decisions.
  assign swap_pend_d = swap_pend_q | bus.raster_done;

  // Saturating drop counter.
  assign oob_cnt_d = (oob_cnt_q == 16'hFFFF) ? oob_cnt_q : oob_cnt_q + 16'd1;

  // y*640 + x as y*512 + y*128 + x; 19 bits holds the max of 307199.
  assign lin_addr = {1'b0, bus.px_y, 9'b0} + {3'b0, bus.px_y, 7'b0} + {9'b0, bus.px_x};
  assign in_range = (bus.px_x <= 10'd639) && (bus.px_y <= 9'd479);

  // Main FSM: pixel acceptance, memory write handshake and bank swap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ACCEPT;
      draw_bank_q <= 1'b0;
      swap_pend_q <= 1'b0;
      swap_done_q <= 1'b0;
      oob_cnt_q   <= 16'd0;
      mem_addr_q  <= 20'd0;
      mem_wdata_q <= 3'd0;
    end else begin
      swap_done_q <= 1'b0;
      case (state_q)
        ACCEPT: begin
          swap_pend_q <= swap_pend_d;
          if (bus.px_wr_en) begin
            // A pixel always completes its handshake here; off-screen ones are dropped.
            if (in_range) begin
              mem_addr_q  <= {draw_bank_q, lin_addr};
              mem_wdata_q <= bus.px_color;
              state_q     <= WRITE;
            end else begin
              oob_cnt_q <= oob_cnt_d;
            end
          end else if (swap_pend_d) begin
            // vsync this cycle is deliberately not honoured: swap waits for the next one.
            state_q <= SWAP_WAIT;
          end
        end
        WRITE: begin
          swap_pend_q <= swap_pend_d;
          if (bus.mem_wr_gnt) state_q <= swap_pend_d ? SWAP_WAIT : ACCEPT;
        end
        SWAP_WAIT: begin
          if (bus.vsync) begin
            // The swap consumes the pending request, including one arriving now.
            draw_bank_q <= ~draw_bank_q;
            swap_pend_q <= 1'b0;
            swap_done_q <= 1'b1;
            state_q     <= ACCEPT;
          end else begin
            swap_pend_q <= swap_pend_d;
          end
        end
        default: state_q <= ACCEPT;
      endcase
    end
  end

  assign bus.frame_ready = (state_q == ACCEPT);
  assign bus.mem_wr_req  = (state_q == WRITE);
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.disp_bank   = ~draw_bank_q;
  assign bus.swap_done   = swap_done_q;
  assign bus.oob_cnt     = oob_cnt_q;

endmodule

// File: doc/frame_buffer_writer.md
FRAME_BUFFER_WRITER -- requirements
Module: frame_buffer_writer

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-low.
REQ-003 px_wr_en  input  1  pixel write request from rasterizer; pixel fields valid while high.
REQ-004 px_x  input  10  pixel column, unsigned.
REQ-005 px_y  input  9  pixel row, unsigned.
REQ-006 px_color  input  3  pixel colour.
REQ-007 raster_done  input  1  one-cycle pulse: rasterizer finished current frame.
REQ-008 vsync  input  1  one-cycle pulse from display timing at start of vertical blank.
REQ-009 mem_wr_gnt  input  1  memory arbiter accepts current write this cycle.
REQ-010 frame_ready  output  1  pixel on px_* accepted this cycle when px_wr_en also high.
REQ-011 mem_wr_req  output  1  write request to frame memory.
REQ-012 mem_addr  output  20  {draw_bank, linear pixel address[18:0]}.
REQ-013 mem_wdata  output  3  colour to write.
REQ-014 disp_bank  output  1  bank the display reads; always ~draw_bank.
REQ-015 swap_done  output  1  one-cycle pulse when banks swap.
REQ-016 oob_cnt  output  16  count of dropped out-of-range pixels, saturating.

Function
REQ-017 FSM states: ACCEPT, WRITE, SWAP_WAIT; frame_ready = (state == ACCEPT), combinational from state only.
REQ-018 Handshake: pixel transfer occurs on any cycle with px_wr_en & frame_ready; the rasterizer advances on that same cycle, so no px_* input is sampled on any other cycle.
REQ-019 In-range pixel (px_x <= 639, px_y <= 479) accepted in ACCEPT: register mem_addr, mem_wdata; next state WRITE.
REQ-020 Linear address = px_y*640 + px_x, computed as (px_y<<9)+(px_y<<7)+px_x, 19 bits, no truncation (max 307199).
REQ-021 mem_addr[19] = draw_bank value at acceptance cycle.
REQ-022 Write latency: pixel accepted in cycle N -> mem_wr_req high from cycle N+1 until the cycle mem_wr_gnt is high, inclusive; mem_addr/mem_wdata stable throughout.
REQ-023 mem_wr_req = (state == WRITE); mem_wr_gnt ignored in other states.
REQ-024 WRITE with mem_wr_gnt: next state SWAP_WAIT if swap_pend set, else ACCEPT; without gnt: stay WRITE.
REQ-025 Out-of-range pixel accepted in ACCEPT: handshake completes, no memory write, oob_cnt += 1 (holds at 16'hFFFF), stay ACCEPT.
REQ-026 raster_done in any state sets swap_pend; swap_pend cleared on swap.
REQ-027 ACCEPT with swap_pend set (or raster_done this cycle) and no px_wr_en: next state SWAP_WAIT.
REQ-028 ACCEPT with px_wr_en and raster_done same cycle: pixel processed per REQ-019/025, swap_pend set, swap follows after the write.
REQ-029 SWAP_WAIT: frame_ready low, no writes; on vsync: draw_bank toggles, swap_pend cleared, swap_done high next cycle for exactly one cycle, next state ACCEPT.
REQ-030 vsync outside SWAP_WAIT: ignored, no bank change.
REQ-031 vsync coincident with raster_done while in ACCEPT: no swap this vsync; swap on next vsync.
REQ-032 disp_bank = ~draw_bank at all times, combinational.

Reset
REQ-033 rst low at any clock edge, including mid-WRITE or SWAP_WAIT: state ACCEPT, draw_bank 0, swap_pend 0, oob_cnt 0, mem_addr 0, mem_wdata 0, swap_done 0; pending write discarded.
REQ-034 Post-reset outputs: frame_ready 1, mem_wr_req 0, disp_bank 1.

Verification
REQ-035 Pixel (x=5,y=2,color=3'b101), gnt tied 1 -> mem_wr_req one cycle later, mem_addr=20'h00505 (1285), mem_wdata=5; frame_ready low one cycle.
REQ-036 Pixel (639,479), gnt held low 4 cycles -> mem_wr_req high 5 cycles, mem_addr=20'h4AFFF (307199) stable, frame_ready low for all 5.
REQ-037 Pixels (640,0) then (0,480) -> no mem_wr_req, frame_ready stays 1, oob_cnt=2.
REQ-038 raster_done, then vsync 10 cycles later -> frame_ready low from the cycle after raster_done until vsync; swap_done pulse; draw_bank=1, disp_bank=0; next pixel (0,0) writes mem_addr=20'h80000.
REQ-039 px_wr_en with raster_done same cycle, gnt delayed 2 cycles, vsync during WRITE -> write completes to bank 0, vsync ignored, swap on following vsync only.
REQ-040 rst low during WRITE -> next cycle mem_wr_req 0, frame_ready 1, draw_bank 0, oob_cnt 0.
